// File: rtl/dot_operand_fetch.sv
// dot_operand_fetch: AXI read master fetching strided A/B element pairs for a MAC stage
module dot_operand_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [15:0]       stride,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              op_last
);
  typedef enum logic [2:0] {IDLE, A_AR, A_R, B_AR, B_R, PUSH, FIN} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] addr_a, addr_b, stride_q;
  logic [LEN_W-1:0]  left;
  logic              r_ok, r_bad, last_pair;
  assign r_ok      = M_AXI_RVALID && (M_AXI_RRESP == 2'b00);
  assign r_bad     = M_AXI_RVALID && (M_AXI_RRESP != 2'b00);
  assign last_pair = (left == LEN_W'(1));
  // state register
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) state <= IDLE;
    else state <= nxt;
  // next-state: one outstanding read at a time, A then B then push
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ((length == '0) ? FIN : A_AR) : IDLE;
      A_AR:    nxt = M_AXI_ARREADY ? A_R : A_AR;
      A_R:     nxt = r_bad ? FIN : (r_ok ? B_AR : A_R);
      B_AR:    nxt = M_AXI_ARREADY ? B_R : B_AR;
      B_R:     nxt = r_bad ? FIN : (r_ok ? PUSH : B_R);
      PUSH:    nxt = op_ready ? (last_pair ? FIN : A_AR) : PUSH;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from state; address registers only move after a push so ARADDR stays stable
  always_comb begin
    M_AXI_ARVALID = (state == A_AR) || (state == B_AR);
    M_AXI_RREADY  = (state == A_R) || (state == B_R);
    M_AXI_ARADDR  = (state == B_AR) ? addr_b : addr_a;
    op_valid      = (state == PUSH);
    op_last       = (state == PUSH) && last_pair;
    busy          = (state != IDLE);
    done          = (state == FIN);
  end
  // job registers, element address accumulation and operand capture
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      addr_a   <= '0;
      addr_b   <= '0;
      stride_q <= '0;
      left     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr_a   <= base_a;
        addr_b   <= base_b;
        stride_q <= {{(ADDR_W-16){1'b0}}, stride};
        left     <= length;
        err      <= 1'b0;
      end
      if (state == A_R && r_ok) op_a <= M_AXI_RDATA;
      if (state == B_R && r_ok) op_b <= M_AXI_RDATA;
      if ((state == A_R || state == B_R) && r_bad) err <= 1'b1;
      if (state == PUSH && op_ready) begin
        addr_a <= addr_a + stride_q;
        addr_b <= addr_b + stride_q;
        left   <= left - LEN_W'(1);
      end
    end
endmodule

// File: tb/tb_dot_operand_fetch.sv
// tb_dot_operand_fetch: directed checks of dot_operand_fetch against a small AXI read slave model
module tb_dot_operand_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, busy, done, err;
  logic [31:0] base_a = '0, base_b = '0;
  logic [15:0] stride = '0;
  logic [15:0] length = '0;
  logic [31:0] araddr, rdata, op_a, op_b;
  logic        arvalid, arready = 1'b1, rvalid, rready, op_valid, op_ready = 1'b1, op_last;
  logic [1:0]  rresp;
  logic        bad_en = 1'b0;
  logic [31:0] bad_addr = '0;
  int tests = 0, fails = 0;
  int done_cnt = 0, overlap = 0, opv_cnt = 0;
  logic [31:0] ar_log[$], pa[$], pb[$];
  logic        pl[$];

  dot_operand_fetch dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .stride(stride), .length(length), .busy(busy), .done(done), .err(err),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready), .op_last(op_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h40:  return 32'd3;
      32'h44:  return 32'd4;
      32'h48:  return 32'hFFFF_FFFB;
      32'h4C:  return 32'd6;
      32'h50:  return 32'd7;
      32'h54:  return 32'hFFFF_FFF8;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // read slave: data one cycle after the address handshake
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= mem(araddr);
      rresp  <= (bad_en && araddr == bad_addr) ? 2'b10 : 2'b00;
    end else if (rvalid && rready) rvalid <= 1'b0;

  always @(negedge clk)
    if (rst_n) begin
      if (arvalid && arready) ar_log.push_back(araddr);
      if (op_valid && op_ready) begin
        pa.push_back(op_a);
        pb.push_back(op_b);
        pl.push_back(op_last);
      end
      if (done) done_cnt++;
      if (arvalid && rready) overlap++;
      if (op_valid) opv_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ar_log.delete(); pa.delete(); pb.delete(); pl.delete();
    done_cnt = 0; overlap = 0; opv_cnt = 0;
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic [15:0] s, input logic [15:0] l);
    @(negedge clk);
    base_a = a; base_b = b; stride = s; length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input int max, input int what);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < max) begin
      @(negedge clk);
      n++;
      hit = (what == 0) ? op_valid : (rready && ar_log.size() == 4);
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    int n;
    #3;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst op_valid", {31'd0, op_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // normal job
    clear_logs();
    go(32'h40, 32'h44, 16'd8, 16'd3);
    wait_done("norm done", 200, n);
    chk("norm ar count", ar_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < ar_log.size(); i++) chk($sformatf("norm araddr%0d", i), ar_log[i], 32'h40 + 4 * i);
    chk("norm pairs", pa.size(), 32'd3);
    if (pa.size() == 3) begin
      chk("norm a0", pa[0], 32'd3);           chk("norm b0", pb[0], 32'd4);
      chk("norm a1", pa[1], 32'hFFFF_FFFB);   chk("norm b1", pb[1], 32'd6);
      chk("norm a2", pa[2], 32'd7);           chk("norm b2", pb[2], 32'hFFFF_FFF8);
      chk("norm last", {29'd0, pl[0], pl[1], pl[2]}, 32'b001);
    end
    chk("norm done pulses", done_cnt, 32'd1);
    chk("norm err", {31'd0, err}, 32'd0);
    chk("norm busy idle", {31'd0, busy}, 32'd0);
    chk("norm overlap", overlap, 32'd0);

    // backpressure on pair 2
    clear_logs();
    op_ready = 1'b0;
    go(32'h40, 32'h44, 16'd8, 16'd3);
    wait_for("bp pair1 valid", 50, 0);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    wait_for("bp pair2 valid", 50, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp op_a", op_a, 32'hFFFF_FFFB);
      chk("bp op_b", op_b, 32'd6);
      chk("bp op_valid", {31'd0, op_valid}, 32'd1);
      chk("bp arvalid", {31'd0, arvalid}, 32'd0);
      @(negedge clk);
    end
    op_ready = 1'b1;
    wait_done("bp done", 200, n);
    chk("bp pairs", pa.size(), 32'd3);
    if (pa.size() == 3) chk("bp b1", pb[1], 32'd6);
    chk("bp ar count", ar_log.size(), 32'd6);

    // zero length
    clear_logs();
    go(32'h40, 32'h44, 16'd8, 16'd0);
    chk("len0 busy", {31'd0, busy}, 32'd1);
    chk("len0 done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("len0 busy off", {31'd0, busy}, 32'd0);
    chk("len0 done off", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    chk("len0 no ar", ar_log.size(), 32'd0);
    chk("len0 done pulses", done_cnt, 32'd1);

    // error on B read of pair 1
    clear_logs();
    bad_en = 1'b1; bad_addr = 32'h44;
    go(32'h40, 32'h44, 16'd8, 16'd3);
    wait_done("err done", 200, n);
    chk("err flag", {31'd0, err}, 32'd1);
    chk("err no op_valid", opv_cnt, 32'd0);
    chk("err done pulses", done_cnt, 32'd1);
    chk("err ar count", ar_log.size(), 32'd2);
    bad_en = 1'b0;
    clear_logs();
    go(32'h40, 32'h44, 16'd8, 16'd1);
    chk("err cleared", {31'd0, err}, 32'd0);
    wait_done("err rerun done", 200, n);
    chk("rerun pairs", pa.size(), 32'd1);
    if (pa.size() == 1) begin
      chk("rerun a0", pa[0], 32'd3);
      chk("rerun b0", pb[0], 32'd4);
      chk("rerun last", {31'd0, pl[0]}, 32'd1);
    end

    // latency and address wrap
    clear_logs();
    go(32'hFFFF_FFF8, 32'h100, 16'd4, 16'd4);
    chk("wrap first arvalid", {31'd0, arvalid}, 32'd1);
    chk("wrap first araddr", araddr, 32'hFFFF_FFF8);
    wait_done("wrap done", 100, n);
    chk("wrap latency", n, 32'd20);
    chk("wrap ar count", ar_log.size(), 32'd8);
    if (ar_log.size() == 8) begin
      chk("wrap a0", ar_log[0], 32'hFFFF_FFF8);
      chk("wrap a1", ar_log[2], 32'hFFFF_FFFC);
      chk("wrap a2", ar_log[4], 32'h0);
      chk("wrap a3", ar_log[6], 32'h4);
      chk("wrap b3", ar_log[7], 32'h10C);
    end
    if (pa.size() == 4) chk("wrap data a2", pa[2], 32'hA5A5_0000);

    // reset during B_R of pair 2
    clear_logs();
    go(32'h40, 32'h44, 16'd8, 16'd3);
    wait_for("mid B_R reached", 50, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid rready", {31'd0, rready}, 32'd0);
    chk("mid op_valid", {31'd0, op_valid}, 32'd0);
    chk("mid op_last", {31'd0, op_last}, 32'd0);
    chk("mid busy", {31'd0, busy}, 32'd0);
    chk("mid done", {31'd0, done}, 32'd0);
    chk("mid err", {31'd0, err}, 32'd0);
    chk("mid araddr", araddr, 32'd0);
    chk("mid op_a", op_a, 32'd0);
    chk("mid op_b", op_b, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid no done", done_cnt, 32'd0);
    clear_logs();
    go(32'h40, 32'h44, 16'd8, 16'd3);
    wait_done("fresh done", 200, n);
    chk("fresh pairs", pa.size(), 32'd3);
    if (pa.size() == 3) begin
      chk("fresh a2", pa[2], 32'd7);
      chk("fresh b2", pb[2], 32'hFFFF_FFF8);
    end
    chk("fresh done pulses", done_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
